// File: rtl/spi_master_if.sv
// Byte-stream and SPI pin bundle for spi_master.
// The master modport is the spi_master view; slave is the user/pin side.
interface spi_master_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       miso;

    modport master (
        input  tx_data, tx_last, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, busy, sck, cs, mosi
    );

    modport slave (
        output tx_data, tx_last, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, busy, sck, cs, mosi
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master: byte stream in/out, CS framing with setup/hold/idle
// timing, back-to-back bytes under one CS via the NEXT state.
module spi_master #(
    parameter int unsigned clk_div  = 4,
    parameter int unsigned cs_setup = 2,
    parameter int unsigned cs_hold  = 2,
    parameter int unsigned cs_idle  = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    spi_master_if.master  bus
);

    localparam int unsigned T01  = (cs_setup > cs_hold) ? cs_setup : cs_hold;
    localparam int unsigned TMAX = (T01 > cs_idle) ? T01 : cs_idle;
    localparam int unsigned CW   = $clog2(TMAX + 1);
    localparam int unsigned DW   = $clog2(clk_div);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        NEXT,
        HOLD,
        RECOVER
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   div_q, div_d;
    logic            half_q, half_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      tx_sr_q, tx_sr_d;
    logic [7:0]      rx_sr_q, rx_sr_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            last_q, last_d;
    logic            sck_q, sck_d;
    logic            cs_q, cs_d;
    logic            rdy_en_q;
    logic            tx_ready;
    logic            accept;

    // rdy_en_q keeps tx_ready low until the first edge after reset release
    assign tx_ready = ((state_q == IDLE) && rdy_en_q) || (state_q == NEXT);
    assign accept   = bus.tx_valid && tx_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        half_d     = half_q;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        last_d     = last_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_sr_d = bus.tx_data;
                    last_d  = bus.tx_last;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(cs_setup - 1)) begin
                    cnt_d   = '0;
                    div_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DW'(clk_div - 1)) begin
                    div_d = '0;
                    if (!half_q) begin
                        // edge raising sck also samples miso
                        half_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[6:0], bus.miso};
                    end else begin
                        half_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_sr_q;
                            cnt_d      = '0;
                            state_d    = last_q ? HOLD : NEXT;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            NEXT: begin
                if (accept) begin
                    tx_sr_d = bus.tx_data;
                    last_d  = bus.tx_last;
                    div_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                if (cnt_q == CW'(cs_hold - 1)) begin
                    cnt_d   = '0;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECOVER: begin
                if (cnt_q == CW'(cs_idle - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // pins are registered from next-state so they change cleanly on the edge
        cs_d  = (state_d == IDLE) || (state_d == RECOVER);
        sck_d = (state_d == SHIFT) && half_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            half_q     <= 1'b0;
            bit_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            last_q     <= last_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            rdy_en_q   <= 1'b1;
        end
    end

    assign bus.tx_ready = tx_ready;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.sck      = sck_q;
    assign bus.cs       = cs_q;
    assign bus.mosi     = tx_sr_q[7];

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table of single-byte transfers plus
// burst, stall, mid-transfer reset and a fast-divider instance.
module tb_spi_master;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic tied1   = 1'b0;

    always #5 clk = ~clk;

    spi_master_if bus ();
    spi_master_if bus2 ();

    spi_master u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    spi_master #(.clk_div(2), .cs_setup(1)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    assign bus.miso  = tied1 ? 1'b1 : bus.mosi;
    assign bus2.miso = bus2.mosi;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // monitor / scoreboard state
    int          t0 = 0, rises = 0, first_rise = -1, cs_low = 0, cs_rises = 0;
    logic [15:0] mosi_log = '0;
    bit          in_burst = 1'b0;
    logic [7:0]  exp_q[$];
    int          acc_q[$];
    int          lat_q[$];

    initial begin : monitor
        logic sck_prev = 1'b0;
        logic cs_prev  = 1'b1;
        logic rv_prev  = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.sck && !sck_prev) begin
                    rises++;
                    if (first_rise < 0) first_rise = cyc - t0;
                    mosi_log = {mosi_log[14:0], bus.mosi};
                end
                if (!bus.cs) cs_low++;
                if (bus.cs && !cs_prev) cs_rises++;
                if (bus.rx_valid) begin
                    check("rx_pulse_width", rv_prev, 0);
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", bus.rx_data, e);
                        check("rx_latency", cyc - acc_q.pop_front(), lat_q.pop_front());
                    end
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (!in_burst) begin
                        t0 = cyc; rises = 0; first_rise = -1;
                        mosi_log = '0; cs_low = 0; cs_rises = 0;
                    end
                    exp_q.push_back(tied1 ? 8'hFF : bus.tx_data);
                    acc_q.push_back(cyc);
                    lat_q.push_back(in_burst ? 65 : 67);
                    in_burst = !bus.tx_last;
                end
            end
            sck_prev = bus.sck;
            cs_prev  = bus.cs;
            rv_prev  = bus.rx_valid;
        end
    end

    // call at posedge+1; returns acceptance cycle relative to transaction start
    task automatic send_byte(input logic [7:0] d, input bit last, input bit hold,
                             output int acc_rel);
        int n = 0;
        bus.tx_data  = d;
        bus.tx_last  = last;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.tx_ready) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        acc_rel = cyc - 1 - t0;
        if (!hold) begin
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'($urandom);
            bus.tx_last  = 1'($urandom);
        end
    endtask

    task automatic wait_idle(output int rel);
        int n = 0;
        while (!bus.tx_ready && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.tx_ready) check("idle_timeout", 0, 1);
        rel = cyc - t0;
    endtask

    task automatic wait_rx();
        int n = 0;
        while (!bus.rx_valid && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.rx_valid) check("rx_timeout", 0, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         tied;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
    } vec_t;

    vec_t vecs[5];

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int acc, rel, bad, n, acc2;
        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 8'hFF, 8'h3C};
        vecs[2] = '{8'h00, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF, 8'hFF};
        vecs[4] = '{8'h5A, 1'b0, 8'h5A, 8'h5A};

        bus.tx_valid  = 1'b0; bus.tx_data  = '0; bus.tx_last  = 1'b0;
        bus2.tx_valid = 1'b0; bus2.tx_data = '0; bus2.tx_last = 1'b0;

        // reset values
        #1 reset_n = 1'b0;
        #11;
        check("rst_cs", bus.cs, 1);
        check("rst_sck", bus.sck, 0);
        check("rst_mosi", bus.mosi, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_busy", bus.busy, 0);
        #10;
        check("rst_tx_ready", bus.tx_ready, 0);
        reset_n = 1'b1;
        #1 check("ready_before_edge", bus.tx_ready, 0);
        @(posedge clk); #1;
        check("ready_first_edge", bus.tx_ready, 1);

        // single-byte table
        for (int i = 0; i < 5; i++) begin
            tied1 = vecs[i].tied;
            send_byte(vecs[i].data, 1'b1, 1'b0, acc);
            wait_idle(rel);
            check("single_ready_again", rel, 71);
            check("single_sck_rises", rises, 8);
            check("single_first_rise", first_rise, 7);
            check("single_mosi_bits", mosi_log[7:0], vecs[i].exp_mosi);
            check("single_cs_low_cycles", cs_low, 68);
            check("single_cs_rises", cs_rises, 1);
            check("single_rx_hold", bus.rx_data, vecs[i].exp_rx);
        end
        tied1 = 1'b0;

        // burst with tx_valid held across bytes
        send_byte(8'h12, 1'b0, 1'b1, acc);
        send_byte(8'h34, 1'b1, 1'b0, acc2);
        check("burst_second_accept", acc2, 67);
        wait_idle(rel);
        check("burst_ready_again", rel, 136);
        check("burst_sck_rises", rises, 16);
        check("burst_mosi_bits", mosi_log, 16'h1234);
        check("burst_cs_low_cycles", cs_low, 133);
        check("burst_cs_rises", cs_rises, 1);

        // stall in NEXT
        send_byte(8'h00, 1'b0, 1'b0, acc);
        wait_rx();
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.cs !== 1'b0 || bus.sck !== 1'b0 || bus.tx_ready !== 1'b1 ||
                bus.busy !== 1'b1) bad++;
        end
        check("stall_hold", bad, 0);
        send_byte(8'hFF, 1'b1, 1'b0, acc2);
        check("stall_accept", acc2, 117);
        wait_idle(rel);
        check("stall_ready_again", rel, 186);
        check("stall_sck_rises", rises, 16);
        check("stall_mosi_bits", mosi_log, 16'h00FF);
        check("stall_cs_rises", cs_rises, 1);

        // reset mid-transfer
        send_byte(8'hA5, 1'b1, 1'b0, acc);
        n = 0;
        while ((cyc - t0) != 30 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("reset_reach_cycle30", cyc - t0, 30);
        check("pre_reset_cs", bus.cs, 0);
        #2 reset_n = 1'b0;
        exp_q.delete(); acc_q.delete(); lat_q.delete();
        in_burst = 1'b0;
        #1;
        check("async_rst_cs", bus.cs, 1);
        check("async_rst_sck", bus.sck, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_ready", bus.tx_ready, 0);
        check("async_rst_rx_data", bus.rx_data, 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", bus.tx_ready, 1);
        send_byte(8'h5A, 1'b1, 1'b0, acc);
        wait_idle(rel);
        check("post_reset_ready_again", rel, 71);
        check("post_reset_sck_rises", rises, 8);

        // fast divider instance: clk_div=2, cs_setup=1
        bus2.tx_data  = 8'hC3;
        bus2.tx_last  = 1'b1;
        bus2.tx_valid = 1'b1;
        n = 0;
        while (!bus2.tx_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        acc = cyc;
        @(posedge clk); #1;
        bus2.tx_valid = 1'b0;
        n = 0;
        while (!bus2.rx_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("fast_latency", cyc - acc, 34);
        check("fast_rx_data", bus2.rx_data, 8'hC3);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter clk_div, default 4, meaning SCK half-period in clk cycles (legal >= 2).
REQ-002 SHALL have parameter cs_setup, default 2, meaning clk cycles CS is low before the first SCK phase (legal >= 1).
REQ-003 SHALL have parameter cs_hold, default 2, meaning clk cycles CS stays low after the last SCK falling edge of a transaction (legal >= 1).
REQ-004 SHALL have parameter cs_idle, default 2, meaning minimum clk cycles CS stays high between transactions (legal >= 1).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 tx_data  input  8  byte to send, MSB first.
REQ-008 tx_last  input  1  qualifies tx_data: 1 ends the transaction after this byte.
REQ-009 tx_valid  input  1  tx_data/tx_last valid.
REQ-010 tx_ready  output  1  block accepts a byte this cycle.
REQ-011 rx_data  output  8  byte received on miso, MSB first.
REQ-012 rx_valid  output  1  one-cycle pulse; rx_data valid.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-015 cs  output  1  chip select, active low.
REQ-016 mosi  output  1  serial data out.
REQ-017 miso  input  1  serial data in, sampled directly (no synchroniser).

Function
REQ-018 SHALL implement states IDLE, SETUP, SHIFT, NEXT, HOLD, RECOVER.
REQ-019 A byte SHALL be accepted only on a cycle where tx_valid and tx_ready are both high; tx_ready SHALL be high only in IDLE and NEXT.
REQ-020 On acceptance in IDLE: latch byte and tx_last, drive mosi = tx_data[7], drive cs low from the next cycle, enter SETUP for cs_setup cycles.
REQ-021 SHIFT SHALL last 16*clk_div cycles: per bit, sck low for clk_div cycles, then high for clk_div cycles; sck starts low on SHIFT entry.
REQ-022 miso SHALL be captured on the clk edge that drives sck 0->1; mosi SHALL advance to the next bit on the clk edge that drives sck 1->0, except after bit 0.
REQ-023 On the first cycle after SHIFT completes, rx_valid SHALL pulse for exactly one cycle with all 8 captured bits; rx_data SHALL hold its value until the next pulse.
REQ-024 Latency: rx_valid SHALL assert 1 + cs_setup + 16*clk_div cycles after the IDLE acceptance cycle (67 with defaults).
REQ-025 After SHIFT: if the latched tx_last is 0, enter NEXT; if 1, enter HOLD.
REQ-026 NEXT: cs stays low, sck stays low, tx_ready high; on acceptance load the byte, set mosi = tx_data[7], and enter SHIFT next cycle with no SETUP. Waiting in NEXT has no time limit.
REQ-027 The NEXT acceptance may coincide with the rx_valid pulse of the previous byte.
REQ-028 HOLD: cs low for cs_hold cycles, then RECOVER: cs high for cs_idle cycles, then IDLE.
REQ-029 tx_valid/tx_data changes outside acceptance cycles SHALL have no effect.
REQ-030 sck SHALL be 0 in every state except the high phases of SHIFT; cs SHALL be high only in IDLE and RECOVER.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, cs=1, sck=0, mosi=0, tx_ready=0, rx_valid=0, rx_data=0x00, busy=0, and clear all counters.
REQ-032 tx_ready SHALL assert on the first clk edge after reset_n deasserts.
REQ-033 Reset during any state, including mid-byte, SHALL abort with no rx_valid; no RECOVER time is enforced afterwards.

Verification
REQ-034 Loopback (miso=mosi), defaults: send 0xA5 with tx_last=1, accepted at cycle 0 -> cs low on cycles 1-68, exactly 8 sck rising edges, first at cycle 7, rx_valid at cycle 67 with rx_data=0xA5, tx_ready again at cycle 71.
REQ-035 Burst: send 0x12 (last=0), then 0x34 (last=1), with tx_valid held -> 0x34 accepted at cycle 67; cs never rises between bytes; rx_valid at 67 (0x12) and 132 (0x34); 16 sck rising edges total.
REQ-036 Stall: send 0x00 (last=0), withhold tx_valid for 50 cycles after rx_valid -> cs stays low, sck stays 0, tx_ready stays 1, busy stays 1; then send 0xFF (last=1) -> normal completion.
REQ-037 miso tied 1, send 0x3C -> mosi bit sequence 0,0,1,1,1,1,0,0 sampled at sck rising edges; rx_data=0xFF.
REQ-038 reset_n pulsed low at cycle 30 of a transaction -> cs=1, sck=0 asynchronously; no rx_valid; a new transfer accepted right after release completes correctly.
REQ-039 clk_div=2, cs_setup=1: single byte -> rx_valid at 1+1+32=34 cycles after acceptance.
